// File: rtl/sram_tiled_ctrl.sv
// Tiled SRAM subsystem: 128x32 single-port macros arranged COLS wide by ROWS deep.
// Latency: read accepted in cycle T is presented in T+2; writes land at the end of the accept cycle.
// Backpressure: a 2-bit credit counter gates o_req_ready so the 3-entry response queue never overflows.

// Behavioural model of the 128x32 macro: port A read/write with per-bit write mask, port B read only.
// Latency: one cycle from MEA to QA on reads; writes land at the clock edge.
// Backpressure: none, QA holds its last value until the next read.
module HL28HKHDDP128x32BIM4W1P0MSA10 (
    input  logic        CLKA,
    input  logic        MEA,
    input  logic        WEA,
    input  logic [6:0]  ADRA,
    input  logic [31:0] DA,
    input  logic [31:0] WEMA,
    input  logic        TEST1A,
    input  logic        RMEA,
    input  logic [3:0]  RMA,
    input  logic        LS,
    output logic [31:0] QA,
    input  logic        CLKB,
    input  logic        MEB,
    input  logic        WEB,
    input  logic [6:0]  ADRB,
    input  logic [31:0] DB,
    input  logic [31:0] WEMB,
    input  logic        TEST1B,
    input  logic        RMEB,
    input  logic [3:0]  RMB,
    output logic [31:0] QB
);
    logic [31:0] mem [128];

    always_ff @(posedge CLKA) begin
        if (MEA) begin
            if (WEA) begin
                mem[ADRA] <= (mem[ADRA] & ~WEMA) | (DA & WEMA);
            end else begin
                QA <= mem[ADRA];
            end
        end
    end

    always_ff @(posedge CLKB) begin
        if (MEB && !WEB) begin
            QB <= mem[ADRB];
        end
    end

    // Test, margin and port-B write pins have no effect in this model.
    logic unused_pins;
    assign unused_pins = ^{TEST1A, RMEA, RMA, LS, TEST1B, RMEB, RMB, DB, WEMB};
endmodule

// Small generic FIFO; the caller guarantees it is never pushed while full.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: head is held stable until out_vld & out_rdy.
module sram_rsp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop     = out_vld & out_rdy;
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_vld) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(in_vld) - CW'(pop);
        end
    end
endmodule

// Top: request decode onto the macro grid, zero-fill sequencer, read return path.
// Latency: read response at T+2, init sweep of 128 cycles after reset release.
// Backpressure: o_req_ready drops when three reads are outstanding, independent of i_rsp_ready.
module sram_tiled_ctrl #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 512,
    parameter bit INIT_ZERO = 1'b1,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [DATA_W-1:0] i_req_bmask,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_init_done
);
    localparam int COLS  = DATA_W / 32;
    localparam int ROWS  = DEPTH / 128;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [6:0]        init_cnt;
    logic              init_done;
    logic [1:0]        credit;
    logic              rd_pend;
    logic [ROW_W-1:0]  rd_row;

    logic [ROW_W-1:0]  req_row;
    logic              init_active;
    logic              req_acc;
    logic              rd_acc;
    logic              rsp_pop;
    logic [ROWS-1:0]   row_me;
    logic              mac_we;
    logic [6:0]        mac_addr;
    logic [DATA_W-1:0] mac_d;
    logic [DATA_W-1:0] mac_wem;
    logic [DATA_W-1:0] row_q [ROWS];
    logic [DATA_W-1:0] rd_q;

    assign req_row     = ROW_W'(i_req_addr >> 7);
    assign init_active = (state == ST_INIT);
    assign req_acc     = i_req_valid & o_req_ready;
    assign rd_acc      = req_acc & ~i_req_we;
    assign rsp_pop     = o_rsp_valid & i_rsp_ready;
    assign o_req_ready = init_done & (credit != 2'd0);
    assign o_init_done = init_done;

    // The zero-fill sweep drives every row at once; normal traffic enables only the addressed row.
    always_comb begin
        row_me = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_me[r] = init_active | (req_acc & (req_row == ROW_W'(r)));
        end
        mac_we   = init_active | i_req_we;
        mac_addr = init_active ? init_cnt : i_req_addr[6:0];
        mac_d    = init_active ? '0 : i_req_wdata;
        mac_wem  = init_active ? '1 : i_req_bmask;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [31:0] qb_unused;
            HL28HKHDDP128x32BIM4W1P0MSA10 u_mac (
                .CLKA   (i_clk),
                .MEA    (row_me[r]),
                .WEA    (mac_we),
                .ADRA   (mac_addr),
                .DA     (mac_d[32*c +: 32]),
                .WEMA   (mac_wem[32*c +: 32]),
                .TEST1A (1'b1),
                .RMEA   (1'b1),
                .RMA    (4'b0011),
                .LS     (1'b0),
                .QA     (row_q[r][32*c +: 32]),
                .CLKB   (i_clk),
                .MEB    (1'b0),
                .WEB    (1'b0),
                .ADRB   (7'd0),
                .DB     (32'd0),
                .WEMB   (32'd0),
                .TEST1B (1'b1),
                .RMEB   (1'b1),
                .RMB    (4'b0011),
                .QB     (qb_unused)
            );
        end
    end

    assign rd_q = row_q[rd_row];

    sram_rsp_fifo #(
        .W     (DATA_W),
        .DEPTH (3)
    ) u_rsp_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .in_vld  (rd_pend),
        .in_dat  (rd_q),
        .out_rdy (i_rsp_ready),
        .out_vld (o_rsp_valid),
        .out_dat (o_rsp_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RESET;
            init_cnt  <= '0;
            init_done <= 1'b0;
            credit    <= 2'd3;
            rd_pend   <= 1'b0;
            rd_row    <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (INIT_ZERO) begin
                        state <= ST_INIT;
                    end else begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_INIT: begin
                    init_cnt <= init_cnt + 7'd1;
                    if (init_cnt == 7'd127) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase

            rd_pend <= rd_acc;
            if (rd_acc) begin
                rd_row <= req_row;
            end
            // One credit per read in flight or queued; pops return it.
            if (rd_acc && !rsp_pop) begin
                credit <= credit - 2'd1;
            end else if (!rd_acc && rsp_pop) begin
                credit <= credit + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_sram_tiled_ctrl.sv
// Bench for sram_tiled_ctrl (64 x 512, zero-fill on): directed vector table plus
// hand sequences for init timing, latency, throughput, back-pressure and mid-read reset.
module tb_sram_tiled_ctrl;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [8:0]  i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic [63:0] i_req_bmask = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [63:0] o_rsp_rdata;
    logic        o_init_done;

    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    int run_len = 0;
    int max_run = 0;

    sram_tiled_ctrl #(
        .DATA_W    (64),
        .DEPTH     (512),
        .INIT_ZERO (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_bmask (i_req_bmask),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_init_done (o_init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [63:0] wdata;
        logic [63:0] bmask;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Presents one request from a negedge and holds it until o_req_ready is seen.
    task automatic issue(input logic we, input logic [8:0] addr, input logic [63:0] wd,
                         input logic [63:0] bm, input logic [63:0] ex);
        int w = 0;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wd;
        i_req_bmask = bm;
        while (!o_req_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!o_req_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: addr %0d never accepted, got ready=0, want 1", addr);
        end else if (!we) begin
            exp_q.push_back(ex);
        end
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        while (exp_q.size() != 0 && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("drain_empty", {63'd0, o_rsp_valid}, 64'd0);
    endtask

    // Called at a negedge: holds reset for 'hold' edges, then times the zero-fill.
    task automatic reset_seq(input int hold);
        int n = 0;
        i_req_valid = 1'b0;
        i_rst = 1'b1;
        exp_q.delete();
        repeat (hold) @(negedge clk);
        check("rst_req_ready", {63'd0, o_req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 64'd0);
        check("rst_init_done", {63'd0, o_init_done}, 64'd0);
        i_rst = 1'b0;
        while (!o_init_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("init_cycles", 64'(n), 64'd129);
        check("init_ready", {63'd0, o_req_ready}, 64'd1);
    endtask

    // Response scoreboard: a pop happens at the posedge after valid & ready are seen here.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (o_rsp_valid && i_rsp_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got %h, want no response", o_rsp_rdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (o_rsp_rdata !== e) begin
                        bad++;
                        $display("FAIL rsp_data: got %h, want %h", o_rsp_rdata, e);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [8:0]  bp_addr [8];
        logic [63:0] bp_exp  [8];
        int k;

        vecs[0]  = '{1'b1, 9'd5,   ALL,                    ALL,                    64'h0};
        vecs[1]  = '{1'b1, 9'd5,   64'h0,                  64'h0000_FFFF_0000_FFFF, 64'h0};
        vecs[2]  = '{1'b0, 9'd5,   64'h0,                  64'h0,                  64'hFFFF_0000_FFFF_0000};
        vecs[3]  = '{1'b1, 9'd127, 64'h1111_1111_2222_2222, ALL,                    64'h0};
        vecs[4]  = '{1'b1, 9'd128, 64'h3333_3333_4444_4444, ALL,                    64'h0};
        vecs[5]  = '{1'b1, 9'd383, 64'h5555_5555_6666_6666, ALL,                    64'h0};
        vecs[6]  = '{1'b1, 9'd511, 64'h7777_7777_8888_8888, ALL,                    64'h0};
        vecs[7]  = '{1'b0, 9'd127, 64'h0,                  64'h0,                  64'h1111_1111_2222_2222};
        vecs[8]  = '{1'b0, 9'd128, 64'h0,                  64'h0,                  64'h3333_3333_4444_4444};
        vecs[9]  = '{1'b0, 9'd383, 64'h0,                  64'h0,                  64'h5555_5555_6666_6666};
        vecs[10] = '{1'b0, 9'd511, 64'h0,                  64'h0,                  64'h7777_7777_8888_8888};
        vecs[11] = '{1'b0, 9'd255, 64'h0,                  64'h0,                  64'h0};
        vecs[12] = '{1'b0, 9'd256, 64'h0,                  64'h0,                  64'h0};
        vecs[13] = '{1'b0, 9'd0,   64'h0,                  64'h0,                  64'h0};
        vecs[14] = '{1'b1, 9'd9,   64'hDEAD_BEEF_0123_4567, ALL,                    64'h0};
        vecs[15] = '{1'b0, 9'd9,   64'h0,                  64'h0,                  64'hDEAD_BEEF_0123_4567};
        vecs[16] = '{1'b1, 9'd383, 64'h0,                  64'h0000_0000_FFFF_FFFF, 64'h0};
        vecs[17] = '{1'b0, 9'd383, 64'h0,                  64'h0,                  64'h5555_5555_0000_0000};

        bp_addr[0] = 9'd127; bp_exp[0] = 64'h1111_1111_2222_2222;
        bp_addr[1] = 9'd128; bp_exp[1] = 64'h3333_3333_4444_4444;
        bp_addr[2] = 9'd383; bp_exp[2] = 64'h5555_5555_0000_0000;
        bp_addr[3] = 9'd511; bp_exp[3] = 64'h7777_7777_8888_8888;
        bp_addr[4] = 9'd9;   bp_exp[4] = 64'hDEAD_BEEF_0123_4567;
        for (int i = 5; i < 8; i++) begin
            bp_addr[i] = 9'd9; bp_exp[i] = 64'hDEAD_BEEF_0123_4567;
        end

        // Power-on reset and zero-fill timing.
        @(negedge clk);
        reset_seq(2);

        // Fill the whole array with nonzero data, reset, and expect all zeros back.
        for (int a = 0; a < 512; a++) begin
            issue(1'b1, 9'(a), {32'hA5A5_A5A5, 23'd0, 9'(a)}, ALL, 64'h0);
        end
        @(negedge clk);
        reset_seq(2);
        for (int a = 0; a < 512; a++) begin
            issue(1'b0, 9'(a), 64'h0, 64'h0, 64'h0);
        end
        drain();

        // Directed vector table: masked writes, row boundaries, write-then-read.
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].bmask, vecs[i].exp);
        end
        drain();

        // Read latency: valid must be low in T+1 and high in T+2.
        issue(1'b0, 9'd5, 64'h0, 64'h0, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);
        i_req_valid = 1'b0;
        check("lat_t1_valid", {63'd0, o_rsp_valid}, 64'd0);
        @(negedge clk);
        check("lat_t2_valid", {63'd0, o_rsp_valid}, 64'd1);
        drain();

        // Throughput and ordering: 32 back-to-back reads must stream without a gap.
        for (int a = 16; a < 48; a++) begin
            issue(1'b1, 9'(a), {32'hC0DE_0000 + 32'(a), 32'h0BAD_0000 + 32'(a)}, ALL, 64'h0);
        end
        drain();
        max_run = 0;
        for (int a = 16; a < 48; a++) begin
            issue(1'b0, 9'(a), 64'h0, 64'h0, {32'hC0DE_0000 + 32'(a), 32'h0BAD_0000 + 32'(a)});
        end
        drain();
        check("stream_run", 64'(max_run), 64'd32);

        // Back-pressure: with no pops only three reads get in.
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            i_rsp_ready = 1'b0;
            i_req_valid = 1'b1;
            i_req_we    = 1'b0;
            i_req_addr  = bp_addr[k];
            i_req_bmask = '0;
            if (o_req_ready && k < 7) begin
                exp_q.push_back(bp_exp[k]);
                k++;
            end
        end
        check("bp_accepted", 64'(k), 64'd3);
        check("bp_ready_low", {63'd0, o_req_ready}, 64'd0);
        @(negedge clk);
        check("bp_head_valid", {63'd0, o_rsp_valid}, 64'd1);
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        check("bp_ready_after_pop", {63'd0, o_req_ready}, 64'd1);
        if (o_req_ready) exp_q.push_back(bp_exp[3]);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        issue(1'b0, bp_addr[4], 64'h0, 64'h0, bp_exp[4]);
        drain();

        // Reset with reads in flight: nothing stale may come out, and credits refill.
        @(negedge clk);
        i_rsp_ready = 1'b0;
        issue(1'b0, 9'd127, 64'h0, 64'h0, 64'h1111_1111_2222_2222);
        issue(1'b0, 9'd128, 64'h0, 64'h0, 64'h3333_3333_4444_4444);
        @(negedge clk);
        i_req_valid = 1'b0;
        check("pre_reset_valid", {63'd0, o_rsp_valid}, 64'd1);
        reset_seq(1);
        i_rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            i_rsp_ready = 1'b0;
            i_req_valid = 1'b1;
            i_req_we    = 1'b0;
            i_req_addr  = 9'd0;
            if (o_req_ready) begin
                exp_q.push_back(64'h0);
                k++;
            end
        end
        check("credit_refill", 64'(k), 64'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
